// File: rtl/mos6502s_mem_pkg.sv
// Shared types, sizing helpers and defaults for the 6502 RAM/ROM memory controller.
package mos6502s_mem_pkg;

    localparam int unsigned WS_W = 4;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    function automatic int unsigned ram_depth(input int unsigned rom_base);
        return rom_base;
    endfunction

    function automatic int unsigned rom_depth(input int unsigned addr_w, input int unsigned rom_base);
        return (32'(1) << addr_w) - rom_base;
    endfunction

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Sizing for the default 16-bit 32K/32K map
    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_ROM_BASE = 16'h8000;
    localparam int unsigned RAM_DEPTH    = ram_depth(DEF_ROM_BASE);
    localparam int unsigned ROM_DEPTH    = rom_depth(DEF_ADDR_W, DEF_ROM_BASE);
    localparam int unsigned RAM_IW       = idx_w(RAM_DEPTH);
    localparam int unsigned ROM_IW       = idx_w(ROM_DEPTH);

endpackage

// File: rtl/mos6502s_memory_ctrl_if.sv
// CPU bus and boot loader signals of the memory controller.
interface mos6502s_memory_ctrl_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_in;
    logic              rw;
    logic              cs;
    logic [7:0]        data_out;
    logic              ready;
    logic              err_wp;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_ready;
    logic              load_done;

    modport master (
        output addr, data_in, rw, cs, load_valid, load_data,
        input  data_out, ready, err_wp, load_ready, load_done
    );

    modport slave (
        input  addr, data_in, rw, cs, load_valid, load_data,
        output data_out, ready, err_wp, load_ready, load_done
    );
endinterface

// File: rtl/mos6502s_mem_bank.sv
// Single-port synchronous byte memory; rdata only updates on a read enable.
module mos6502s_mem_bank
    import mos6502s_mem_pkg::*;
#(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned IW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    // Contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= 8'h00;
        else if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/mos6502s_memory_ctrl.sv
// RAM/ROM controller for the 6502 bus: boot loader, wait states, registered reads, ROM write-protect.
module mos6502s_memory_ctrl
    import mos6502s_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned ROM_BASE    = 16'h8000,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          ROM_WP      = 1'b1,
    parameter bit          BOOT_LOAD   = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    mos6502s_memory_ctrl_if.slave bus
);
    localparam int unsigned RAM_WORDS = ram_depth(ROM_BASE);
    localparam int unsigned ROM_WORDS = rom_depth(ADDR_W, ROM_BASE);
    localparam int unsigned RAM_AW    = idx_w(RAM_WORDS);
    localparam int unsigned ROM_AW    = idx_w(ROM_WORDS);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(ROM_BASE);
    localparam logic [WS_W-1:0]   WS_LOAD = WS_W'(WAIT_STATES);
    localparam logic [ROM_AW-1:0] PTR_END = ROM_AW'(ROM_WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              rw_q;
    logic [WS_W-1:0]   wcnt;
    logic [ROM_AW-1:0] ptr;
    logic              load_done_q;
    logic              ready_q;
    logic              err_q;
    logic              wp_hit;
    logic              rd_rom_q;

    logic              is_rom, in_access, in_boot, capture;
    logic              ram_we, ram_re, rom_we, rom_re;
    logic [RAM_AW-1:0] ram_idx;
    logic [ROM_AW-1:0] rom_idx;
    logic [7:0]        rom_wdata, ram_rdata, rom_rdata;

    assign is_rom    = (addr_q >= BASE_A);
    assign in_access = (state == ST_ACCESS);
    assign in_boot   = (state == ST_BOOT);
    assign capture   = bus.cs && ((state == ST_IDLE) || (state == ST_DONE));

    assign ram_we  = in_access && !rw_q && !is_rom;
    assign ram_re  = in_access &&  rw_q && !is_rom;
    assign rom_re  = in_access &&  rw_q &&  is_rom;
    assign ram_idx = RAM_AW'(addr_q);

    // ROM write port is shared between the loader and unprotected CPU writes
    assign rom_we    = (in_boot && bus.load_valid) || (in_access && !rw_q && is_rom && !ROM_WP);
    assign rom_idx   = in_boot ? ptr : ROM_AW'(addr_q - BASE_A);
    assign rom_wdata = in_boot ? bus.load_data : wdata_q;

    mos6502s_mem_bank #(.DEPTH(RAM_WORDS)) u_ram (
        .clk(clk), .rst_n(rst_n), .we(ram_we), .re(ram_re),
        .idx(ram_idx), .wdata(wdata_q), .rdata(ram_rdata)
    );

    mos6502s_mem_bank #(.DEPTH(ROM_WORDS)) u_rom (
        .clk(clk), .rst_n(rst_n), .we(rom_we), .re(rom_re),
        .idx(rom_idx), .wdata(rom_wdata), .rdata(rom_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT_LOAD ? ST_BOOT : ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            rw_q        <= 1'b1;
            wcnt        <= '0;
            ptr         <= '0;
            load_done_q <= !BOOT_LOAD;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            wp_hit      <= 1'b0;
            rd_rom_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_BOOT: begin
                    if (bus.load_valid) begin
                        ptr <= ptr + ROM_AW'(1);
                        if (ptr == PTR_END) begin
                            load_done_q <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: ;
                ST_WAIT: begin
                    if (wcnt == WS_W'(1)) state <= ST_ACCESS;
                    else                  wcnt  <= wcnt - WS_W'(1);
                end
                ST_ACCESS: begin
                    state  <= ST_DONE;
                    wp_hit <= !rw_q && is_rom && ROM_WP;
                    if (rw_q) rd_rom_q <= is_rom;
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    err_q   <= wp_hit;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // New request in IDLE, or back-to-back from DONE
            if (capture) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.data_in;
                rw_q    <= bus.rw;
                wcnt    <= WS_LOAD;
                state   <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
        end
    end

    assign bus.data_out   = rd_rom_q ? rom_rdata : ram_rdata;
    assign bus.ready      = ready_q;
    assign bus.err_wp     = err_q;
    assign bus.load_ready = in_boot;
    assign bus.load_done  = load_done_q;
endmodule

// File: tb/tb_mos6502s_memory_ctrl.sv
// Two controller instances (0 wait states + ROM protected, 3 wait states + ROM writable) against a byte-array model.
module tb_mos6502s_memory_ctrl;
    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] addr_v [2];
    logic [7:0] din_v  [2];
    logic       rw_v   [2];
    logic       cs_v   [2];
    logic       lv;
    logic [7:0] ld;

    logic [7:0] dout   [2];
    logic       rdy    [2];
    logic       errw   [2];
    logic       lready [2];
    logic       ldone  [2];

    mos6502s_memory_ctrl_if #(.ADDR_W(10)) bus0 ();
    mos6502s_memory_ctrl_if #(.ADDR_W(10)) bus1 ();

    assign bus0.addr = addr_v[0]; assign bus0.data_in = din_v[0];
    assign bus0.rw   = rw_v[0];   assign bus0.cs      = cs_v[0];
    assign bus0.load_valid = lv;  assign bus0.load_data = ld;
    assign bus1.addr = addr_v[1]; assign bus1.data_in = din_v[1];
    assign bus1.rw   = rw_v[1];   assign bus1.cs      = cs_v[1];
    assign bus1.load_valid = lv;  assign bus1.load_data = ld;

    assign dout[0] = bus0.data_out; assign rdy[0] = bus0.ready; assign errw[0] = bus0.err_wp;
    assign lready[0] = bus0.load_ready; assign ldone[0] = bus0.load_done;
    assign dout[1] = bus1.data_out; assign rdy[1] = bus1.ready; assign errw[1] = bus1.err_wp;
    assign lready[1] = bus1.load_ready; assign ldone[1] = bus1.load_done;

    mos6502s_memory_ctrl #(.ADDR_W(10), .ROM_BASE(10'h200), .WAIT_STATES(WS0),
                           .ROM_WP(1'b1), .BOOT_LOAD(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mos6502s_memory_ctrl #(.ADDR_W(10), .ROM_BASE(10'h200), .WAIT_STATES(WS1),
                           .ROM_WP(1'b0), .BOOT_LOAD(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int total = 0;
    int bad   = 0;

    logic [7:0] mm [2][1024];
    logic [7:0] last_rd [2];
    int         ws_of [2];
    bit         wp_of [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_dout"},  32'(dout[k]),   32'h0);
            chk({tag, "_ready"}, 32'(rdy[k]),    32'h0);
            chk({tag, "_err"},   32'(errw[k]),   32'h0);
            chk({tag, "_lrdy"},  32'(lready[k]), 32'h1);
            chk({tag, "_ldone"}, 32'(ldone[k]),  32'h0);
            last_rd[k] = 8'h00;
        end
    endtask

    // Feed n loader bytes to both instances with random gaps while cs pokes at the bus
    task automatic load_bytes(input int n, input bit pattern, output int ready_hits);
        int idx = 0;
        int cyc = 0;
        logic [7:0] b;
        ready_hits = 0;
        b = pattern ? 8'hA5 : 8'($urandom);
        while (idx < n && cyc < 6000) begin
            @(negedge clk);
            if (rdy[0] || rdy[1]) ready_hits++;
            for (int k = 0; k < 2; k++) begin
                cs_v[k]   = (idx < 511);
                addr_v[k] = 10'($urandom);
                rw_v[k]   = 1'($urandom);
            end
            lv = ($urandom_range(0, 3) != 0);
            ld = b;
            @(posedge clk);
            cyc++;
            if (lv) begin
                mm[0][512 + idx] = b;
                mm[1][512 + idx] = b;
                idx++;
                b = pattern ? (8'(idx) ^ 8'hA5) : 8'($urandom);
            end
        end
        @(negedge clk);
        if (rdy[0] || rdy[1]) ready_hits++;
        lv = 1'b0;
        cs_v[0] = 1'b0;
        cs_v[1] = 1'b0;
        chk("load_count", 32'(idx), 32'(n));
    endtask

    task automatic access(input int k, input logic [9:0] a, input logic rwv, input logic [7:0] d);
        logic [7:0] exp_d;
        bit         exp_err;
        int         lat;
        exp_err = !rwv && (a >= 10'h200) && wp_of[k];
        if (rwv) begin
            exp_d      = mm[k][a];
            last_rd[k] = exp_d;
        end else begin
            exp_d = last_rd[k];
            if (!exp_err) mm[k][a] = d;
        end
        @(negedge clk);
        addr_v[k] = a; din_v[k] = d; rw_v[k] = rwv; cs_v[k] = 1'b1;
        @(posedge clk);
        #1 cs_v[k] = 1'b0;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy[k]) begin
                lat = n;
                break;
            end
        end
        chk($sformatf("lat%0d_%03h", k, a), 32'(lat), 32'(ws_of[k] + 2));
        chk($sformatf("dout%0d_%03h", k, a), 32'(dout[k]), 32'(exp_d));
        chk($sformatf("err%0d_%03h", k, a), 32'(errw[k]), 32'(exp_err));
        @(negedge clk);
        chk($sformatf("rdy_pulse%0d", k), 32'(rdy[k]), 32'h0);
        chk($sformatf("err_pulse%0d", k), 32'(errw[k]), 32'h0);
    endtask

    // Two reads with cs held through DONE so the second is captured back-to-back
    task automatic b2b(input int k, input logic [9:0] a1, input logic [9:0] a2);
        int n1, gap;
        @(negedge clk);
        addr_v[k] = a1; rw_v[k] = 1'b1; cs_v[k] = 1'b1;
        @(posedge clk);
        #1 addr_v[k] = a2;
        n1 = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy[k]) begin
                n1 = n;
                break;
            end
        end
        cs_v[k] = 1'b0;
        chk($sformatf("b2b_lat%0d", k), 32'(n1), 32'(ws_of[k] + 2));
        chk($sformatf("b2b_d1_%0d", k), 32'(dout[k]), 32'(mm[k][a1]));
        gap = -1;
        for (int m = 1; m < 40; m++) begin
            @(negedge clk);
            if (rdy[k]) begin
                gap = m;
                break;
            end
        end
        chk($sformatf("b2b_gap%0d", k), 32'(gap), 32'(ws_of[k] + 2));
        chk($sformatf("b2b_d2_%0d", k), 32'(dout[k]), 32'(mm[k][a2]));
        last_rd[k] = mm[k][a2];
        @(negedge clk);
        chk($sformatf("b2b_end%0d", k), 32'(rdy[k]), 32'h0);
    endtask

    initial begin
        int hits;
        ws_of[0] = WS0; ws_of[1] = WS1;
        wp_of[0] = 1'b1; wp_of[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            addr_v[k] = '0; din_v[k] = '0; rw_v[k] = 1'b1; cs_v[k] = 1'b0;
        end
        lv = 1'b0; ld = 8'h00;

        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        // Partial load with noise, then reset mid-load
        load_bytes(100, 1'b0, hits);
        chk("boot_ready_partial", 32'(hits), 32'h0);
        chk("mid_ldone0", 32'(ldone[0]), 32'h0);
        chk("mid_lrdy1",  32'(lready[1]), 32'h1);
        rst_n = 1'b0;
        #1 chk_reset("midload_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Full reload from index 0
        load_bytes(512, 1'b1, hits);
        chk("boot_ready_full", 32'(hits), 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ldone%0d", k), 32'(ldone[k]), 32'h1);
            chk($sformatf("lrdy%0d", k),  32'(lready[k]), 32'h0);
        end
        access(0, 10'h200, 1'b1, 8'h00);
        access(1, 10'h200, 1'b1, 8'h00);
        access(0, 10'h3FF, 1'b1, 8'h00);
        access(1, 10'h264, 1'b1, 8'h00);

        access(0, 10'h055, 1'b0, 8'h3C);
        access(0, 10'h055, 1'b1, 8'h00);
        access(1, 10'h055, 1'b0, 8'hC3);
        access(1, 10'h055, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_dout1", 32'(dout[1]), 32'(last_rd[1]));
            chk("hold_rdy1",  32'(rdy[1]),  32'h0);
        end

        access(0, 10'h3FF, 1'b0, 8'h00);
        access(0, 10'h3FF, 1'b1, 8'h00);
        access(1, 10'h3FF, 1'b0, 8'h77);
        access(1, 10'h3FF, 1'b1, 8'h00);
        access(0, 10'h1FF, 1'b0, 8'hE1);
        access(0, 10'h000, 1'b0, 8'h1E);
        access(0, 10'h1FF, 1'b1, 8'h00);
        access(0, 10'h000, 1'b1, 8'h00);

        access(0, 10'h010, 1'b0, 8'h11);
        access(0, 10'h011, 1'b0, 8'h22);
        access(1, 10'h010, 1'b0, 8'h33);
        access(1, 10'h011, 1'b0, 8'h44);
        b2b(0, 10'h010, 10'h011);
        b2b(1, 10'h010, 10'h011);

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++)
                access(k, 10'($urandom), 1'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
